// File: rtl/bram2rgb.sv
// Frame-buffer scan-out: generates 720p timing and reads the BRAM frame with each pixel repeated 2^SCALE_LOG2 x 2^SCALE_LOG2.
// Counter-to-output latency RD_LATENCY+2 pclk cycles; free-running raster, no backpressure accepted.
module bram2rgb #(
  parameter int ACTIVE_COLS = 320,
  parameter int ACTIVE_ROWS = 180,
  parameter int SCALE_LOG2  = 2,
  parameter int H_ACTIVE    = 1280,
  parameter int H_FP        = 110,
  parameter int H_SYNC      = 40,
  parameter int H_BP        = 220,
  parameter int V_ACTIVE    = 720,
  parameter int V_FP        = 5,
  parameter int V_SYNC      = 5,
  parameter int V_BP        = 20,
  parameter int SYNC_POL    = 1,
  parameter int RD_LATENCY  = 1,
  parameter int ADDR_W      = 16
) (
  input  logic              pclk,
  input  logic              rst,
  input  logic [23:0]       bram_data,
  output logic [ADDR_W-1:0] bramaddr,
  output logic              bram_en,
  output logic              o_HSync,
  output logic              o_VSync,
  output logic              o_vde,
  output logic [23:0]       o_rgb,
  output logic              start_frame
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [HW-1:0] COLS   = HW'(ACTIVE_COLS);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [VW-1:0] ROWS   = VW'(ACTIVE_ROWS);

  localparam logic [ADDR_W-1:0]     LINE_STEP = ADDR_W'(ACTIVE_COLS);
  localparam logic [SCALE_LOG2-1:0] SUB_LAST  = '1;
  localparam logic                  POL       = (SYNC_POL != 0);

  logic [HW-1:0]     hcnt;
  logic [VW-1:0]     vcnt;
  logic [ADDR_W-1:0] line_base;
  logic [HW-1:0]     src_col;
  logic [VW-1:0]     src_row;
  logic              active;
  logic              in_win;
  logic              hs_raw;
  logic              vs_raw;
  logic              first_px;

  logic [RD_LATENCY:0] act_sr;
  logic [RD_LATENCY:0] win_sr;
  logic [RD_LATENCY:0] hs_sr;
  logic [RD_LATENCY:0] vs_sr;
  logic [RD_LATENCY:0] first_sr;

  assign src_col  = hcnt >> SCALE_LOG2;
  assign src_row  = vcnt >> SCALE_LOG2;
  assign active   = (hcnt < H_ACT) && (vcnt < V_ACT);
  assign in_win   = active && (src_col < COLS) && (src_row < ROWS);
  assign hs_raw   = (hcnt >= HS_BEG) && (hcnt < HS_END);
  assign vs_raw   = (vcnt >= VS_BEG) && (vcnt < VS_END);
  assign first_px = (hcnt == '0) && (vcnt == '0);

  // line_base tracks src_row*ACTIVE_COLS by stepping once per group of replicated lines.
  always_ff @(posedge pclk) begin
    if (rst) begin
      hcnt      <= '0;
      vcnt      <= '0;
      line_base <= '0;
    end else if (hcnt == H_LAST) begin
      hcnt <= '0;
      if (vcnt == V_LAST) begin
        vcnt      <= '0;
        line_base <= '0;
      end else begin
        vcnt <= vcnt + VW'(1);
        if (vcnt[SCALE_LOG2-1:0] == SUB_LAST)
          line_base <= line_base + LINE_STEP;
      end
    end else begin
      hcnt <= hcnt + HW'(1);
    end
  end

  // Address only moves inside the source window, so it never passes the last frame address.
  always_ff @(posedge pclk) begin
    if (rst) begin
      bramaddr <= '0;
      bram_en  <= 1'b0;
    end else begin
      bram_en <= in_win;
      if (in_win)
        bramaddr <= line_base + ADDR_W'(src_col);
    end
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      act_sr   <= '0;
      win_sr   <= '0;
      hs_sr    <= '0;
      vs_sr    <= '0;
      first_sr <= '0;
    end else begin
      act_sr   <= {act_sr[RD_LATENCY-1:0], active};
      win_sr   <= {win_sr[RD_LATENCY-1:0], in_win};
      hs_sr    <= {hs_sr[RD_LATENCY-1:0], hs_raw};
      vs_sr    <= {vs_sr[RD_LATENCY-1:0], vs_raw};
      first_sr <= {first_sr[RD_LATENCY-1:0], first_px};
    end
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      o_vde       <= 1'b0;
      o_rgb       <= '0;
      o_HSync     <= ~POL;
      o_VSync     <= ~POL;
      start_frame <= 1'b0;
    end else begin
      o_vde       <= act_sr[RD_LATENCY];
      o_rgb       <= win_sr[RD_LATENCY] ? bram_data : 24'h000000;
      o_HSync     <= hs_sr[RD_LATENCY] ? POL : ~POL;
      o_VSync     <= vs_sr[RD_LATENCY] ? POL : ~POL;
      start_frame <= first_sr[RD_LATENCY] & act_sr[RD_LATENCY];
    end
  end

endmodule

// File: tb/tb_bram2rgb.sv
// Bench for bram2rgb: full-size 720p instance, reduced-timing instances (read latency 1 and 2), and a narrow-window instance.
module tb_bram2rgb;

  logic pclk = 1'b0;
  logic rst;
  always #5 pclk = ~pclk;

  // A: default 720p, latency 1
  logic [15:0] addr_a; logic en_a, hs_a, vs_a, vde_a, sf_a; logic [23:0] rgb_a, q_a;
  // B: reduced timing, latency 1
  logic [15:0] addr_b; logic en_b, hs_b, vs_b, vde_b, sf_b; logic [23:0] rgb_b, q_b;
  // C: reduced timing, latency 2
  logic [15:0] addr_c; logic en_c, hs_c, vs_c, vde_c, sf_c; logic [23:0] rgb_c, q_c1, q_c2;
  // D: default timing, 300-column source
  logic [15:0] addr_d; logic en_d, hs_d, vs_d, vde_d, sf_d; logic [23:0] rgb_d, q_d;

  bram2rgb u_a (.pclk(pclk), .rst(rst), .bram_data(q_a), .bramaddr(addr_a), .bram_en(en_a),
                .o_HSync(hs_a), .o_VSync(vs_a), .o_vde(vde_a), .o_rgb(rgb_a), .start_frame(sf_a));

  bram2rgb #(.ACTIVE_COLS(8), .ACTIVE_ROWS(4), .SCALE_LOG2(1), .H_ACTIVE(16), .H_FP(2), .H_SYNC(3),
             .H_BP(3), .V_ACTIVE(8), .V_FP(1), .V_SYNC(2), .V_BP(1), .RD_LATENCY(1))
    u_b (.pclk(pclk), .rst(rst), .bram_data(q_b), .bramaddr(addr_b), .bram_en(en_b),
         .o_HSync(hs_b), .o_VSync(vs_b), .o_vde(vde_b), .o_rgb(rgb_b), .start_frame(sf_b));

  bram2rgb #(.ACTIVE_COLS(8), .ACTIVE_ROWS(4), .SCALE_LOG2(1), .H_ACTIVE(16), .H_FP(2), .H_SYNC(3),
             .H_BP(3), .V_ACTIVE(8), .V_FP(1), .V_SYNC(2), .V_BP(1), .RD_LATENCY(2))
    u_c (.pclk(pclk), .rst(rst), .bram_data(q_c2), .bramaddr(addr_c), .bram_en(en_c),
         .o_HSync(hs_c), .o_VSync(vs_c), .o_vde(vde_c), .o_rgb(rgb_c), .start_frame(sf_c));

  bram2rgb #(.ACTIVE_COLS(300))
    u_d (.pclk(pclk), .rst(rst), .bram_data(q_d), .bramaddr(addr_d), .bram_en(en_d),
         .o_HSync(hs_d), .o_VSync(vs_d), .o_vde(vde_d), .o_rgb(rgb_d), .start_frame(sf_d));

  // BRAM models: read data equals the address
  always @(posedge pclk) begin
    if (en_a) q_a <= {8'h00, addr_a};
    if (en_b) q_b <= {8'h00, addr_b};
    if (en_c) q_c1 <= {8'h00, addr_c};
    q_c2 <= q_c1;
    if (en_d) q_d <= {8'h00, addr_d};
  end

  typedef struct {
    int          k;
    logic [15:0] addr;
    logic        en;
    logic        vde;
    logic [23:0] rgb;
    logic        hs;
    logic        sf;
    string       name;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;
  int   k;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, k);
    end
  endtask

  task automatic add(input int kk, input int addr, input logic en, input logic vde,
                     input int rgb, input logic hs, input logic sf, input string nm);
    vec_t v;
    v.k = kk; v.addr = 16'(addr); v.en = en; v.vde = vde; v.rgb = 24'(rgb);
    v.hs = hs; v.sf = sf; v.name = nm;
    vecs.push_back(v);
  endtask

  task automatic tick();
    @(posedge pclk);
    @(negedge pclk);
    k++;
  endtask

  // Reference raster: returns {start_frame, vsync, hsync, vde, rgb} for output position d.
  function automatic logic [27:0] exp_out(input int d, input int ht, input int vt, input int ha,
                                          input int va, input int hsb, input int hse, input int vsb,
                                          input int vse, input int s, input int cols, input int rows);
    int col, row, pix;
    logic act, win, hs, vs, sf;
    if (d < 0) return 28'h0;
    col = d % ht;
    row = (d / ht) % vt;
    act = (col < ha) && (row < va);
    win = act && ((col >> s) < cols) && ((row >> s) < rows);
    pix = win ? ((row >> s) * cols + (col >> s)) : 0;
    hs  = (col >= hsb) && (col < hse);
    vs  = (row >= vsb) && (row < vse);
    sf  = (col == 0) && (row == 0);
    return {sf, vs, hs, act, 24'(pix)};
  endfunction

  function automatic logic [27:0] exp_big(input int d, input int cols);
    return exp_out(d, 1650, 750, 1280, 720, 1390, 1430, 725, 730, 2, cols, 180);
  endfunction

  function automatic logic [27:0] exp_small(input int d);
    return exp_out(d, 24, 12, 16, 8, 18, 21, 9, 11, 1, 8, 4);
  endfunction

  localparam int NMAIN = 8300;

  initial begin
    int vi, mis_a, mis_b, mis_c, mis_d, vde_cnt_b, sf_cnt_b, vs_cnt_b, max_b;
    int vde_cnt_r, sf_cnt_r, mis_r;
    logic pre_vde;

    // k, bramaddr, bram_en, o_vde, o_rgb, o_HSync, start_frame
    add(1,    0,   1, 0, 0,   0, 0, "rel1");
    add(2,    0,   1, 0, 0,   0, 0, "rel2");
    add(3,    0,   1, 1, 0,   0, 1, "first_vde");
    add(4,    0,   1, 1, 0,   0, 0, "px1");
    add(5,    1,   1, 1, 0,   0, 0, "addr1");
    add(7,    1,   1, 1, 1,   0, 0, "px4");
    add(1280, 319, 1, 1, 319, 0, 0, "last_addr_l0");
    add(1281, 319, 0, 1, 319, 0, 0, "en_off_l0");
    add(1283, 319, 0, 0, 0,   0, 0, "vde_off_l0");
    add(1392, 319, 0, 0, 0,   0, 0, "hs_pre");
    add(1393, 319, 0, 0, 0,   1, 0, "hs_rise");
    add(1432, 319, 0, 0, 0,   1, 0, "hs_last");
    add(1433, 319, 0, 0, 0,   0, 0, "hs_fall");
    add(1652, 0,   1, 0, 0,   0, 0, "l1_addr");
    add(1653, 0,   1, 1, 0,   0, 0, "l1_vde");
    add(3042, 319, 0, 0, 0,   0, 0, "hs2_pre");
    add(3043, 319, 0, 0, 0,   1, 0, "hs2_rise");
    add(4957, 1,   1, 1, 1,   0, 0, "l3_px4");
    add(6601, 320, 1, 0, 0,   0, 0, "l4_addr");
    add(6603, 320, 1, 1, 320, 0, 0, "l4_first");
    add(7882, 639, 0, 1, 639, 0, 0, "l4_last");

    rst = 1'b1;
    k = 0;
    repeat (10) @(posedge pclk);
    @(negedge pclk);
    chk("rst_addr",  32'(addr_a), 0);
    chk("rst_en",    32'(en_a),   0);
    chk("rst_vde",   32'(vde_a),  0);
    chk("rst_rgb",   32'(rgb_a),  0);
    chk("rst_hs",    32'(hs_a),   0);
    chk("rst_vs",    32'(vs_a),   0);
    chk("rst_sf",    32'(sf_a),   0);
    chk("rst_others", 32'({vde_b, en_b, vde_c, en_c, vde_d, en_d, sf_b, sf_c, sf_d}), 0);
    rst = 1'b0;

    vi = 0; mis_a = 0; mis_b = 0; mis_c = 0; mis_d = 0;
    vde_cnt_b = 0; sf_cnt_b = 0; vs_cnt_b = 0; max_b = 0;
    for (int i = 1; i <= NMAIN; i++) begin
      tick();
      if (vi < vecs.size() && vecs[vi].k == k) begin
        chk({vecs[vi].name, "_addr"}, 32'(addr_a), 32'(vecs[vi].addr));
        chk({vecs[vi].name, "_en"},   32'(en_a),   32'(vecs[vi].en));
        chk({vecs[vi].name, "_vde"},  32'(vde_a),  32'(vecs[vi].vde));
        chk({vecs[vi].name, "_rgb"},  32'(rgb_a),  32'(vecs[vi].rgb));
        chk({vecs[vi].name, "_hs"},   32'(hs_a),   32'(vecs[vi].hs));
        chk({vecs[vi].name, "_sf"},   32'(sf_a),   32'(vecs[vi].sf));
        vi++;
      end
      if ({sf_a, vs_a, hs_a, vde_a, rgb_a} !== exp_big(k - 3, 320)) mis_a++;
      if ({sf_b, vs_b, hs_b, vde_b, rgb_b} !== exp_small(k - 3)) mis_b++;
      if ({sf_c, vs_c, hs_c, vde_c, rgb_c} !== exp_small(k - 4)) mis_c++;
      if (k <= 1650 && {sf_d, vs_d, hs_d, vde_d, rgb_d} !== exp_big(k - 3, 300)) mis_d++;
      if (k - 1 >= 1200 && k - 1 < 1650 && (en_d !== 1'b0 || addr_d !== 16'd299)) mis_d++;
      if (k <= 578) begin
        vde_cnt_b += int'(vde_b);
        sf_cnt_b  += int'(sf_b);
        vs_cnt_b  += int'(vs_b);
      end
      if (int'(addr_b) > max_b) max_b = int'(addr_b);
      if (k == 186) chk("b_last_pixel", 32'(rgb_b), 31);
      if (k == 218) chk("b_vs_pre", 32'(vs_b), 0);
      if (k == 219) chk("b_vs_rise", 32'(vs_b), 1);
      if (k == 3)   chk("c_vde_not_yet", 32'({vde_c, sf_c}), 0);
      if (k == 4)   chk("c_vde_lat4", 32'({vde_c, sf_c}), 32'b11);
      if (k == 1200) chk("d_addr_299", 32'({en_d, addr_d}), 32'({1'b1, 16'd299}));
    end
    chk("table_consumed", 32'(vi), 32'(vecs.size()));
    chk("a_stream_mismatches", 32'(mis_a), 0);
    chk("b_stream_mismatches", 32'(mis_b), 0);
    chk("c_stream_mismatches", 32'(mis_c), 0);
    chk("d_window_mismatches", 32'(mis_d), 0);
    chk("b_vde_per_2frames", 32'(vde_cnt_b), 256);
    chk("b_sf_per_2frames", 32'(sf_cnt_b), 2);
    chk("b_vs_per_2frames", 32'(vs_cnt_b), 96);
    chk("b_addr_ceiling", 32'(max_b), 31);

    // Mid-frame reset on the reduced raster: line 5, column 10
    for (int i = 0; i < 300 && (k % 288) != 130; i++) tick();
    pre_vde = vde_b;
    chk("b_pre_reset_vde", 32'(pre_vde), 1);
    rst = 1'b1;
    @(posedge pclk);
    @(negedge pclk);
    chk("b_mid_reset_outs", 32'({vde_b, en_b, sf_b, hs_b, vs_b, rgb_b, addr_b}), 0);
    rst = 1'b0;
    k = 0;
    vde_cnt_r = 0; sf_cnt_r = 0; mis_r = 0;
    for (int i = 1; i <= 290; i++) begin
      tick();
      if (k == 1) chk("b_restart_addr", 32'({en_b, addr_b}), 32'({1'b1, 16'd0}));
      if (k == 2) chk("b_restart_no_partial", 32'(vde_b), 0);
      if (k == 3) chk("b_restart_sf", 32'({vde_b, sf_b, rgb_b}), 32'({1'b1, 1'b1, 24'd0}));
      if ({sf_b, vs_b, hs_b, vde_b, rgb_b} !== exp_small(k - 3)) mis_r++;
      vde_cnt_r += int'(vde_b);
      sf_cnt_r  += int'(sf_b);
    end
    chk("b_restart_stream", 32'(mis_r), 0);
    chk("b_restart_vde_cnt", 32'(vde_cnt_r), 128);
    chk("b_restart_sf_once", 32'(sf_cnt_r), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
